// File: rtl/delay_stage_arbiter_pkg.sv
// Shared types and constants for the delay-stage arbiter slice.
package delay_stage_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam int BEAT_W = 4;

endpackage

// File: rtl/delay_stage_arbiter_rr_pick.sv
// Round-robin picker: first valid index at or above ptr, wrapping around.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    idx,
    output logic             found
);

    logic [IW-1:0] cand;

    // Walk downward so the candidate closest to ptr is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + IW'(k);
            if (valid[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/delay_stage_arbiter.sv
// Round-robin arbiter feeding N_REQ requesters into one registered delay stage,
// with bounded bursts per grant.
module delay_stage_arbiter
    import delay_stage_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 16,
    parameter int BURST_MAX = 4,
    localparam int IW       = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IW-1:0]           grant_id,
    output logic                    busy,
    output state_t                  fsm_state,
    output logic [BEAT_W-1:0]       beat_cnt,
    output logic [IW-1:0]           ptr
);

    // Handshake: a beat moves when valid and ready are both high at a rising edge.

    state_t            state;
    state_t            state_next;
    logic [IW-1:0]     pick_idx;
    logic              pick_found;
    logic              stage_open;
    logic              xfer;
    logic              burst_done;
    logic              release_grant;
    logic [DATA_W-1:0] grant_data;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign stage_open    = !out_valid || out_ready;
    assign grant_data    = req_data[grant_id*DATA_W +: DATA_W];
    assign xfer          = req_valid[grant_id] && req_ready[grant_id];
    assign burst_done    = xfer && (beat_cnt + BEAT_W'(1) == BEAT_W'(BURST_MAX));
    assign release_grant = (state == SERVE) && (!req_valid[grant_id] || burst_done);
    assign busy          = (state == SERVE);
    assign fsm_state     = state;

    always_comb begin
        req_ready = '0;
        if (state == SERVE && stage_open) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_found)    state_next = SERVE;
            SERVE:   if (release_grant) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_id <= '0;
            beat_cnt <= '0;
            ptr      <= '0;
        end else begin
            if (state == IDLE && pick_found) begin
                grant_id <= pick_idx;
                beat_cnt <= '0;
            end
            if (xfer) begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
            end
            if (release_grant) begin
                ptr <= grant_id + IW'(1);
            end
        end
    end

    // Delay stage: load on transfer, otherwise hold data and drop valid once consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_data  <= grant_data;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_delay_stage_arbiter.sv
// Bench for delay_stage_arbiter: vector table, directed corner sequences and
// randomized traffic against a cycle-level reference model with a scoreboard.
module tb_delay_stage_arbiter;
  import delay_stage_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int BM = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      grant_id;
  logic            busy;
  state_t          fsm_state;
  logic [3:0]      beat_cnt;
  logic [1:0]      ptr;

  delay_stage_arbiter #(.N_REQ(N), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .fsm_state (fsm_state),
    .beat_cnt  (beat_cnt),
    .ptr       (ptr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // reference model and scoreboard
  bit            m_serve;
  int            m_gid, m_ptr, m_beats;
  bit            m_ov;
  logic [DW-1:0] m_od;
  logic [DW-1:0] exp_q[$];

  task automatic model_reset();
    m_serve = 0; m_gid = 0; m_ptr = 0; m_beats = 0; m_ov = 0; m_od = '0;
    exp_q.delete();
  endtask

  function automatic logic [N-1:0] m_ready();
    if (m_serve && (!m_ov || out_ready)) return N'(1 << m_gid);
    return '0;
  endfunction

  task automatic model_check();
    logic [DW-1:0] front;
    chk("ctl", {busy, fsm_state, req_ready, out_valid, grant_id, beat_cnt, ptr},
        {m_serve, state_t'(m_serve), m_ready(), m_ov, 2'(m_gid), 4'(m_beats), 2'(m_ptr)});
    chk("data", out_data, m_od);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        front = exp_q.pop_front();
        chk("sb_beat", out_data, front);
      end
    end
  endtask

  task automatic model_step();
    logic [N-1:0] rdy;
    bit x;
    int j;
    if (!rst) begin
      model_reset();
      return;
    end
    rdy = m_ready();
    x = m_serve && rdy[m_gid] && req_valid[m_gid];
    if (x) begin
      m_od = req_data[m_gid*DW +: DW];
      m_ov = 1;
      m_beats++;
      exp_q.push_back(m_od);
    end else if (m_ov && out_ready) begin
      m_ov = 0;
    end
    if (m_serve) begin
      if (!req_valid[m_gid] || (x && m_beats == BM)) begin
        m_serve = 0;
        m_ptr = (m_gid + 1) % N;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (req_valid[j]) begin
          m_gid = j; m_beats = 0; m_serve = 1;
          break;
        end
      end
    end
  endtask

  // driver tasks: inputs change at negedge, outputs sampled 1 unit later
  task automatic cyc();
    #1;
    model_check();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0;
    model_reset();
    #1;
    chk("reset_state", {req_ready, out_data, out_valid, grant_id, busy, beat_cnt, ptr}, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0]  rv;
    logic [DW-1:0] d0;
    logic          ordy;
    logic          busy;
    logic [N-1:0]  rdy;
    logic          ov;
    logic [DW-1:0] od;
    logic [1:0]    gid;
  } vec_t;

  vec_t tbl[10];
  int   grants[$];
  int   beats[N];
  logic prev_busy;

  initial begin
    // single requester, burst of four then a second grant
    tbl[0] = '{4'b0001, 16'h1111, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h0000, 2'd0};
    tbl[1] = '{4'b0001, 16'h1111, 1'b1, 1'b1, 4'b0001, 1'b0, 16'h0000, 2'd0};
    tbl[2] = '{4'b0001, 16'h1112, 1'b1, 1'b1, 4'b0001, 1'b1, 16'h1111, 2'd0};
    tbl[3] = '{4'b0001, 16'h1113, 1'b1, 1'b1, 4'b0001, 1'b1, 16'h1112, 2'd0};
    tbl[4] = '{4'b0001, 16'h1114, 1'b1, 1'b1, 4'b0001, 1'b1, 16'h1113, 2'd0};
    tbl[5] = '{4'b0001, 16'h1115, 1'b1, 1'b0, 4'b0000, 1'b1, 16'h1114, 2'd0};
    tbl[6] = '{4'b0001, 16'h1115, 1'b1, 1'b1, 4'b0001, 1'b0, 16'h1114, 2'd0};
    tbl[7] = '{4'b0001, 16'h1116, 1'b1, 1'b1, 4'b0001, 1'b1, 16'h1115, 2'd0};
    tbl[8] = '{4'b0000, 16'h1116, 1'b1, 1'b1, 4'b0001, 1'b1, 16'h1116, 2'd0};
    tbl[9] = '{4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h1116, 2'd0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].rv;
      req_data  = {48'h0, tbl[i].d0};
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d", i), {busy, req_ready, out_valid, out_data, grant_id},
          {tbl[i].busy, tbl[i].rdy, tbl[i].ov, tbl[i].od, tbl[i].gid});
      cyc();
    end

    // all four requesters continuously valid
    do_reset();
    req_valid = 4'b1111; out_ready = 1'b1;
    prev_busy = 1'b0;
    for (int i = 0; i < N; i++) beats[i] = 0;
    for (int c = 0; c < 26; c++) begin
      req_data = {$urandom, $urandom};
      #1;
      if (busy && !prev_busy) grants.push_back(int'(grant_id));
      if ((req_ready & req_valid) != '0) beats[grant_id]++;
      prev_busy = busy;
      cyc();
    end
    chk("rr_count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk($sformatf("rr_grant%0d", i), grants[i], i % N);
    chk("rr_beats0", beats[0], 8);
    for (int i = 1; i < N; i++) chk($sformatf("rr_beats%0d", i), beats[i], 4);

    // back-pressure holds the stage
    do_reset();
    req_valid = 4'b0001; out_ready = 1'b1; req_data = {48'h0, 16'hA5A5};
    cyc();
    cyc();
    out_ready = 1'b0; req_data = {48'h0, 16'hB6B6};
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_hold%0d", c), {out_valid, out_data, req_ready, beat_cnt, busy},
          {1'b1, 16'hA5A5, 4'b0000, 4'd1, 1'b1});
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    #1;
    chk("bp_resume", {out_data, beat_cnt}, {16'hB6B6, 4'd2});
    req_valid = '0;
    cyc();
    cyc();

    // early drop by requester 2, then wrap-around 3 -> 0
    do_reset();
    req_valid = 4'b0100; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req_data = {$urandom, $urandom};
      cyc();
    end
    req_valid = 4'b1001;
    #1;
    chk("drop_pre", {busy, grant_id, beat_cnt}, {1'b1, 2'd2, 4'd2});
    cyc();
    #1;
    chk("drop_release", {busy, ptr}, {1'b0, 2'd3});
    cyc();
    #1;
    chk("wrap_grant3", {busy, grant_id}, {1'b1, 2'd3});
    for (int c = 0; c < 4; c++) begin
      req_data = {$urandom, $urandom};
      cyc();
    end
    #1;
    chk("wrap_release", {busy, ptr}, {1'b0, 2'd0});
    cyc();
    #1;
    chk("wrap_grant0", {busy, grant_id}, {1'b1, 2'd0});
    req_valid = '0;
    cyc();
    cyc();

    // asynchronous reset in the middle of a burst
    do_reset();
    req_valid = 4'b1000; out_ready = 1'b1; req_data = {16'hC3C3, 48'h0};
    cyc();
    cyc();
    #1;
    chk("mid_pre", {busy, out_valid, grant_id}, {1'b1, 1'b1, 2'd3});
    #1;
    rst = 1'b0;
    #1;
    chk("mid_reset", {req_ready, out_data, out_valid, grant_id, busy, beat_cnt, ptr}, '0);
    model_reset();
    req_valid = 4'b0110;
    cyc();
    rst = 1'b1;
    cyc();
    #1;
    chk("post_reset_grant", {busy, grant_id}, {1'b1, 2'd1});
    req_valid = '0;
    cyc();
    cyc();

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req_valid = N'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      req_data = {$urandom, $urandom};
      cyc();
    end
    req_valid = '0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) cyc();
    chk("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_stage_arbiter.md
DELAY_STAGE_ARBITER -- requirements
Module: delay_stage_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the stage (power of 2, 2..8).
REQ-002 Parameter DATA_W, default 16, data width of each requester and of the shared stage.
REQ-003 Parameter BURST_MAX, default 4, maximum beats per grant (1..15).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 req_valid  input  N_REQ  per-requester data valid.
REQ-007 req_data  input  N_REQ*DATA_W  packed request data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 req_ready  output  N_REQ  per-requester accept; one-hot or zero.
REQ-009 out_data  output  DATA_W  registered shared-stage data.
REQ-010 out_valid  output  1  out_data holds an unconsumed beat.
REQ-011 out_ready  input  1  downstream accept.
REQ-012 grant_id  output  clog2(N_REQ)  index of the current or last grantee.
REQ-013 busy  output  1  high in SERVE.

Function
REQ-014 The FSM SHALL have two states: IDLE and SERVE.
REQ-015 IDLE: if any req_valid is high, the FSM SHALL select the first valid index, scanning upward from ptr with wrap-around, register it in grant_id, clear beat_cnt and enter SERVE next cycle; otherwise it SHALL stay in IDLE.
REQ-016 req_ready[grant_id] SHALL equal (state==SERVE) && (!out_valid || out_ready); all other req_ready bits SHALL be 0.
REQ-017 A transfer SHALL occur when req_valid[grant_id] && req_ready[grant_id]; out_data SHALL load req_data of grant_id and out_valid SHALL be 1 on the next edge (1-cycle latency).
REQ-018 With no transfer, out_valid && out_ready SHALL clear out_valid, and out_data SHALL hold its value.
REQ-019 Simultaneous consume and transfer SHALL keep out_valid at 1 and load the new data (no bubble).
REQ-020 Each transfer SHALL increment beat_cnt (4-bit, no wrap within a grant).
REQ-021 SERVE SHALL release to IDLE on the edge where a transfer makes beat_cnt reach BURST_MAX, or in any cycle where req_valid[grant_id] is low.
REQ-022 On release, ptr SHALL become grant_id+1 modulo N_REQ; grant_id SHALL hold its value in IDLE.
REQ-023 Back-pressure in SERVE (out_ready low, out_valid high) SHALL stall without releasing the grant and without counting beats.
REQ-024 Request latency: req_valid rising in IDLE at cycle t -> req_ready at t+1 -> out_valid at t+2.
REQ-025 A requester SHALL NOT be granted twice in a row while another requester is valid at the release cycle.

Reset
REQ-026 rst low SHALL immediately force state=IDLE, ptr=0, grant_id=0, beat_cnt=0, out_valid=0, out_data=0, req_ready=0, busy=0.
REQ-027 Reset asserted mid-burst SHALL discard the in-flight grant; the first post-reset grant SHALL scan from index 0.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE, SERVE) and the beat-counter width constant.
REQ-029 The round-robin priority picker (valid vector plus ptr -> index plus found flag) SHALL be a combinational sub-module named rr_pick.
REQ-030 The output register SHALL be an enable-gated DATA_W register with the same hold semantics as the team's 1-cycle delay stage.

Verification
REQ-031 Single requester: req_valid=0001, data 0x1111..0x1116, out_ready=1 -> beats 0x1111..0x1114, release, one IDLE cycle, then 0x1115, 0x1116.
REQ-032 All four valid continuously, out_ready=1 -> grant_id sequence 0,1,2,3,0, four beats each.
REQ-033 Back-pressure: out_ready=0 for 3 cycles mid-burst -> out_data held at 0xA5A5, req_ready=0, beat_cnt frozen, no data loss.
REQ-034 Early drop: requester 2 sends 2 beats then drops valid -> release after 2 beats, ptr=3, requester 3 granted next.
REQ-035 Reset mid-burst: rst low during SERVE with out_valid=1 -> all outputs 0 immediately; with 0110 valid after release, grant_id=1.
REQ-036 Wrap-around: ptr=3, req_valid=1001 -> grant_id=3, then 0.
